// File: rtl/wrr_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_pkt_arbiter
//   Packet-aware weighted round-robin arbiter. ARB_NUM request ports offer
//   data beats tagged with an end-of-packet flag. Once a port wins, the grant
//   stays with it until its last beat has been accepted. A port may win up to
//   weight[i] consecutive packets before the pointer moves on. Accepted beats
//   pass through one registered output stage with a valid/ready handshake.
//
// Ports
//   iClk, iRst_n  clock, asynchronous active-low reset
//   iReq/iLast    per-port beat valid / end-of-packet (iLast qualified by iReq)
//   iData         per-port beat data, packed [ARB_NUM-1:0][DW-1:0]
//   oGnt          one-hot combinational beat accept
//   oReq/oLast    registered output beat valid / end-of-packet
//   oData/oPort   registered output beat data / source port
//   iGnt          downstream ready; a beat leaves when oReq & iGnt
//   iWeightLoad   one-cycle strobe that latches iWeight into the weight regs
//   iWeight       per-port weights, unpacked [ARB_NUM][WW]
//
// Optional feature (macro WRR_GNT_CNT_EN)
//   Adds oPktCnt[ARB_NUM][16]: per-port count of granted last beats,
//   wrapping, cleared by reset and by iWeightLoad.
// ---------------------------------------------------------------------------
module wrr_pkt_arbiter #(
  parameter int ARB_NUM = 4,
  parameter int DW      = 8,
  parameter int WW      = 4
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic [ARB_NUM-1:0]         iReq,
  input  logic [ARB_NUM-1:0]         iLast,
  input  logic [ARB_NUM-1:0][DW-1:0] iData,
  output logic [ARB_NUM-1:0]         oGnt,
  output logic                       oReq,
  output logic                       oLast,
  output logic [DW-1:0]              oData,
  output logic [$clog2(ARB_NUM)-1:0] oPort,
  input  logic                       iGnt,
  input  logic                       iWeightLoad,
  input  logic [WW-1:0]              iWeight [ARB_NUM]
`ifdef WRR_GNT_CNT_EN
  ,
  output logic [15:0]                oPktCnt [ARB_NUM]
`endif
);

  localparam int PW = $clog2(ARB_NUM);

  logic [PW-1:0] ptr;
  logic [WW-1:0] credit;
  logic          locked;
  // Set by reset: the very first selection starts its scan at ptr itself so
  // that the first round after reset begins at port 0.
  logic          fresh;
  logic [WW-1:0] weight [ARB_NUM];

  logic          stageFree;
  logic          gntValid;
  logic          reload;
  logic          acceptLast;
  logic [PW-1:0] gntIdx;
  logic [PW-1:0] scanIdx;
  int            scanPos;
  logic [WW-1:0] creditBase;
  logic [WW-1:0] creditNext;

  assign stageFree = !oReq || iGnt;

  // Port selection. Normally the scan covers ptr+1 .. ptr+ARB_NUM, i.e. the
  // current owner is tried last, so a lone requester with spent credit still
  // wins again and gets its credit reloaded.
  always_comb begin
    gntValid = 1'b0;
    reload   = 1'b0;
    gntIdx   = ptr;
    scanIdx  = ptr;
    scanPos  = 0;
    if (stageFree) begin
      if (locked) begin
        gntValid = iReq[ptr];
      end else if (iReq[ptr] && credit != '0 && weight[ptr] != '0) begin
        gntValid = 1'b1;
      end else begin
        for (int k = 0; k < ARB_NUM; k++) begin
          scanPos = (int'(ptr) + k + (fresh ? 0 : 1)) % ARB_NUM;
          scanIdx = PW'(scanPos);
          if (!gntValid && iReq[scanIdx] && weight[scanIdx] != '0) begin
            gntValid = 1'b1;
            reload   = 1'b1;
            gntIdx   = scanIdx;
          end
        end
      end
    end
  end

  // Grant is suppressed while reset is held so nothing is accepted then.
  always_comb begin
    oGnt = '0;
    if (gntValid && iRst_n) oGnt[gntIdx] = 1'b1;
  end

  // Credit counts packets, so it only moves on a granted last beat.
  assign acceptLast = gntValid && iLast[gntIdx];
  assign creditBase = reload ? weight[gntIdx] : credit;
  assign creditNext = (acceptLast && creditBase != '0) ? creditBase - WW'(1) : creditBase;

  // Arbitration state and output stage
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oReq   <= 1'b0;
      oLast  <= 1'b0;
      oData  <= '0;
      oPort  <= '0;
      ptr    <= '0;
      credit <= '0;
      locked <= 1'b0;
      fresh  <= 1'b1;
      for (int i = 0; i < ARB_NUM; i++) weight[i] <= WW'(1);
    end else begin
      if (iWeightLoad) begin
        for (int i = 0; i < ARB_NUM; i++) weight[i] <= iWeight[i];
      end
      if (gntValid) begin
        oReq   <= 1'b1;
        oLast  <= acceptLast;
        oData  <= iData[gntIdx];
        oPort  <= gntIdx;
        ptr    <= gntIdx;
        credit <= creditNext;
        locked <= !acceptLast;
        fresh  <= 1'b0;
      end else if (iGnt) begin
        oReq <= 1'b0;
      end
    end
  end

`ifdef WRR_GNT_CNT_EN
  // Per-port packet counters
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < ARB_NUM; i++) oPktCnt[i] <= '0;
    end else begin
      for (int i = 0; i < ARB_NUM; i++) begin
        if (iWeightLoad) begin
          oPktCnt[i] <= '0;
        end else if (acceptLast && gntIdx == PW'(i)) begin
          oPktCnt[i] <= oPktCnt[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
